// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions for the ID-stage hazard logic.
//   REG_W    : architectural register-index width (16 registers)
//   slot_t   : shadow copy of one in-flight instruction's destination state
//   BUBBLE   : empty slot (all fields zero)
//   slot_hit : true when a slot will write back register r
package pipeline_pkg;

    localparam int unsigned REG_W = 4;

    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] dest;
        logic             wb_en;
        logic             mem_read;
    } slot_t;

    localparam slot_t BUBBLE = '0;

    function automatic logic slot_hit(input slot_t s, input logic [REG_W-1:0] r);
        return s.valid & s.wb_en & (s.dest == r);
    endfunction

endpackage

// File: rtl/hazard_match.sv
// Compares one ID source register against the EXE and MEM shadow slots.
// Ports:
//   exe_slot, mem_slot : current shadow slots
//   src                : source register index read by the ID instruction
//   src_en             : source is actually read (gates both match terms)
//   m_exe, m_mem       : source is produced by the EXE / MEM instruction
module hazard_match
    import pipeline_pkg::*;
(
    input  slot_t            exe_slot,
    input  slot_t            mem_slot,
    input  logic [REG_W-1:0] src,
    input  logic             src_en,
    output logic             m_exe,
    output logic             m_mem
);

    always_comb begin
        m_exe = src_en & slot_hit(exe_slot, src);
        m_mem = src_en & slot_hit(mem_slot, src);
    end

endmodule

// File: rtl/hazard_stall_unit.sv
// ID-stage stall decision for the 5-stage pipeline. Keeps a shadow copy of
// the EXE and MEM destination state, advanced in lock-step with the pipeline
// registers (held on freeze), and raises hazard_detected when the ID
// instruction cannot proceed.
// Ports:
//   clk, rst           : clock, synchronous active-low reset
//   freeze             : memory wait, all state holds
//   flush              : branch taken, ID instruction discarded
//   Forward_En         : forwarding enabled; only load-use stalls remain
//   id_valid, src1, src2, two_src, id_dest, id_wb_en, id_mem_read : ID instr
//   hazard_detected    : stall IF/ID, bubble into ID-EXE
//   mem_dest, mem_wb_en: shadow MEM slot for cross-checking
//   stall_count        : saturating count of stall cycles taken
module hazard_stall_unit
    import pipeline_pkg::*;
#(
    // Must match pipeline_pkg::REG_W, which sizes the shadow slots.
    parameter int unsigned REG_W = pipeline_pkg::REG_W,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             freeze,
    input  logic             flush,
    input  logic             Forward_En,
    input  logic             id_valid,
    input  logic [REG_W-1:0] src1,
    input  logic [REG_W-1:0] src2,
    input  logic             two_src,
    input  logic [REG_W-1:0] id_dest,
    input  logic             id_wb_en,
    input  logic             id_mem_read,
    output logic             hazard_detected,
    output logic [REG_W-1:0] mem_dest,
    output logic             mem_wb_en,
    output logic [CNT_W-1:0] stall_count
);

    slot_t            exe_q, exe_d;
    slot_t            mem_q;
    logic [CNT_W-1:0] cnt_q;

    logic m1_exe, m1_mem, m2_exe, m2_mem;
    logic hazard;

    hazard_match u_match_src1 (
        .exe_slot (exe_q),
        .mem_slot (mem_q),
        .src      (src1),
        .src_en   (1'b1),
        .m_exe    (m1_exe),
        .m_mem    (m1_mem)
    );

    hazard_match u_match_src2 (
        .exe_slot (exe_q),
        .mem_slot (mem_q),
        .src      (src2),
        .src_en   (two_src),
        .m_exe    (m2_exe),
        .m_mem    (m2_mem)
    );

    // Flush wins over any hazard: the ID instruction is being discarded.
    always_comb begin
        hazard = 1'b0;
        if (id_valid && !flush) begin
            if (Forward_En) begin
                // Only a load result in EXE is too late to forward.
                hazard = (m1_exe | m2_exe) & exe_q.mem_read;
            end else begin
                hazard = m1_exe | m1_mem | m2_exe | m2_mem;
            end
        end
    end

    always_comb begin
        exe_d = BUBBLE;
        if (id_valid && !hazard && !flush) begin
            exe_d.valid    = 1'b1;
            exe_d.dest     = id_dest;
            exe_d.wb_en    = id_wb_en;
            exe_d.mem_read = id_mem_read;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            exe_q <= BUBBLE;
            mem_q <= BUBBLE;
            cnt_q <= '0;
        end else if (!freeze) begin
            mem_q <= exe_q;
            exe_q <= exe_d;
            if (hazard && (cnt_q != '1)) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign hazard_detected = hazard;
    assign mem_dest        = mem_q.dest;
    assign mem_wb_en       = mem_q.valid & mem_q.wb_en;
    assign stall_count     = cnt_q;

endmodule

// File: doc/hazard_stall_unit.md
Name: hazard_stall_unit

Overview:
- Stall-side counterpart to the forwarding path in the 5-stage ARM pipeline. Where forwarding supplies bypassed operands, this block decides when the ID stage must stall instead.
- Keeps its own shadow copy of the destination-register state of the instructions in EXE and MEM. It advances that copy in lock-step with the pipeline registers, honouring the SRAM freeze and branch flush.
- Raises hazard_detected to freeze PC/IF-ID and inject a bubble into ID-EXE. Also exports a saturating stall counter for performance measurement.

Parameters:
- REG_W, 4, register-index width (16 architectural registers).
- CNT_W, 16, width of the stall counter.

Ports:
- clk  input  1  pipeline clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-low reset (0 = reset), sampled on the clk rising edge.
- freeze  input  1  SRAM wait from the memory stage; all shadow state holds while 1.
- flush  input  1  branch taken; the ID instruction is discarded.
- Forward_En  input  1  forwarding enabled (mode switch).
- id_valid  input  1  ID holds a real instruction.
- src1  input  REG_W  first source register of the ID instruction (always read).
- src2  input  REG_W  second source register of the ID instruction.
- two_src  input  1  src2 is actually read (register-operand or store).
- id_dest  input  REG_W  destination register of the ID instruction.
- id_wb_en  input  1  the ID instruction writes back.
- id_mem_read  input  1  the ID instruction is a load.
- hazard_detected  output  1  stall IF/ID and bubble ID-EXE this cycle.
- mem_dest  output  REG_W  shadow MEM-stage destination (debug/cross-check against the pipeline register).
- mem_wb_en  output  1  shadow MEM-stage write-back enable (valid & wb_en).
- stall_count  output  CNT_W  number of stall cycles taken.

Behaviour:
- Shadow slot format: {valid, dest, wb_en, mem_read}. There are two slots, EXE and MEM.
- Reset (rst=0 at an edge):
  - both slots are cleared (valid=0, other fields 0);
  - stall_count=0;
  - consequently hazard_detected=0, mem_dest=0 and mem_wb_en=0 from the following cycle on.
  - Reset takes priority over freeze and flush.
- Advance (rst=1, freeze=0), every edge:
  - MEM slot <= EXE slot.
  - EXE slot <= {1, id_dest, id_wb_en, id_mem_read} when id_valid & !hazard_detected & !flush; otherwise a bubble (valid=0).
- Hold (rst=1, freeze=1): both slots keep their values and stall_count is unchanged.
- Match terms, evaluated combinationally on the current slots and the ID inputs:
  - m_exe(s) = exe.valid & exe.wb_en & (exe.dest == s).
  - m_mem(s) = mem.valid & mem.wb_en & (mem.dest == s).
  - The s=src2 terms are gated by two_src.
- hazard_detected, combinational, forced to 0 when id_valid=0 or flush=1:
  - Forward_En=0: 1 if any of m_exe(src1), m_mem(src1), m_exe(src2), m_mem(src2) is true.
  - Forward_En=1: 1 only on a load-use conflict, i.e. (m_exe(src1) | m_exe(src2)) & exe.mem_read. MEM-stage matches and non-load EXE matches are resolved by forwarding and do not stall.
  - hazard_detected is still reported while freeze=1; the pipeline is held anyway.
- Stall latency:
  - A load-use stall lasts exactly 1 unfrozen cycle.
  - With Forward_En=0, a dependence on EXE stalls 2 unfrozen cycles and a dependence on MEM stalls 1.
  - No stall for WB-stage producers; the register file writes on the negative edge.
- stall_count: increments by 1 on each edge where rst=1, freeze=0 and hazard_detected=1. It saturates at all-ones with no wrap.
- mem_wb_en = mem.valid & mem.wb_en. mem_dest = mem.dest.
- Simultaneous events: flush has priority over hazard (no stall, bubble inserted). A flush mid-stall therefore drops the stalled instruction.
- Destination register 15 (PC) is tracked like any other register; no special casing.

Decomposition:
- Shared package pipeline_pkg holds:
  - REG_W;
  - the shadow-slot struct {valid, dest[REG_W], wb_en, mem_read};
  - a BUBBLE constant (all zero).
- One natural sub-module, hazard_match: combinational slot-vs-source comparator producing m_exe/m_mem for one source. It is instantiated twice, for src1 and src2.

Test Plan:
- Reset: rst=0 for 2 cycles with id_valid=1 and a matching src → hazard_detected=0, stall_count=0, mem_wb_en=0.
- Load-use: Forward_En=1, load R3 issued, next ID src1=3 → hazard_detected=1 for exactly 1 cycle, then 0; stall_count=1. Also with two_src=0 and src2=3 → no stall.
- No-forward RAW: Forward_En=0, ADD R2 issued, next ID src2=2 with two_src=1 → 2 stall cycles; stall_count=2. With one independent instruction in between → 1 stall.
- Forwardable: Forward_En=1, ADD R5 followed by src1=5 → hazard_detected=0 throughout; mem_dest=5 and mem_wb_en=1 two cycles after issue.
- Freeze: load R4, next src1=4, freeze=1 for 3 cycles → hazard held at 1, stall_count unchanged during freeze. After release: +1 count, then hazard=0.
- Flush priority: load R1 then src1=1 with flush=1 → hazard_detected=0, EXE slot becomes a bubble, stall_count unchanged. Saturation: preload near max by stalling repeatedly at CNT_W=4 → count stops at 15.
